// File: rtl/pulse_burst_ctrl_pkg.sv
// Shared constants for the pulse burst sequencer: register map, control bits and FSM states.
package pulse_ctrl_pkg;

    localparam logic [2:0] ADDR_W1    = 3'd0;
    localparam logic [2:0] ADDR_W2    = 3'd1;
    localparam logic [2:0] ADDR_GAP   = 3'd2;
    localparam logic [2:0] ADDR_COUNT = 3'd3;
    localparam logic [2:0] ADDR_PER   = 3'd4;
    localparam logic [2:0] ADDR_CTRL  = 3'd5;

    localparam int CTRL_START   = 0;
    localparam int CTRL_ABORT   = 1;
    localparam int CTRL_KEY_EN  = 2;
    localparam int CTRL_CLR_ERR = 3;

    localparam int DEF_MIN_PERIOD = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        FIRE = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/pulse_burst_ctrl_if.sv
// Host register-write bus from the UART command decoder into the burst sequencer.
interface pulse_burst_ctrl_if;

    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;

    modport master (output cfg_we, output cfg_addr, output cfg_wdata);
    modport slave  (input  cfg_we, input  cfg_addr, input  cfg_wdata);

endinterface

// File: rtl/pulse_burst_ctrl_cfg_regs.sv
// Staged (shadow) configuration registers, key enable and control-write decode.
module pulse_cfg_regs
    import pulse_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    input  logic             key_trig,
    output logic [15:0]      stg_width1,
    output logic [15:0]      stg_width2,
    output logic [15:0]      stg_gap,
    output logic [15:0]      stg_count,
    output logic [CNT_W-1:0] stg_period,
    output logic             start_req,
    output logic             abort_req,
    output logic             clr_err
);

    logic key_en;
    logic ctrl_wr;

    assign ctrl_wr = cfg_we && (cfg_addr == ADDR_CTRL);

    // key_en is the registered value, so a key press coinciding with a
    // control write is judged against the setting before that write.
    assign start_req = (ctrl_wr && cfg_wdata[CTRL_START]) || (key_trig && key_en);
    assign abort_req = ctrl_wr && cfg_wdata[CTRL_ABORT];
    assign clr_err   = ctrl_wr && cfg_wdata[CTRL_CLR_ERR];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stg_width1 <= '0;
            stg_width2 <= '0;
            stg_gap    <= '0;
            stg_count  <= '0;
            stg_period <= '0;
            key_en     <= 1'b0;
        end else if (cfg_we) begin
            case (cfg_addr)
                ADDR_W1:    stg_width1 <= cfg_wdata[15:0];
                ADDR_W2:    stg_width2 <= cfg_wdata[15:0];
                ADDR_GAP:   stg_gap    <= cfg_wdata[15:0];
                ADDR_COUNT: stg_count  <= cfg_wdata[15:0];
                ADDR_PER:   stg_period <= cfg_wdata[CNT_W-1:0];
                ADDR_CTRL:  key_en     <= cfg_wdata[CTRL_KEY_EN];
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pulse_burst_ctrl.sv
// Burst sequencer: loads staged shape into the active copy and fires N triggers at period_act spacing.
module pulse_burst_ctrl
    import pulse_ctrl_pkg::*;
#(
    parameter int FIRE_HOLD  = 4,
    parameter int MIN_PERIOD = DEF_MIN_PERIOD,
    parameter int CNT_W      = 32
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    pulse_burst_ctrl_if.slave   cfg,
    input  logic                key_trig,
    output logic [15:0]         pulse_width1,
    output logic [15:0]         pulse_width2,
    output logic [15:0]         pulse_gap,
    output logic                fire,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
);

    logic [15:0]      stg_width1, stg_width2, stg_gap, stg_count;
    logic [CNT_W-1:0] stg_period;
    logic             start_req, abort_req, clr_err;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_act;
    logic [15:0]      remaining;
    logic             load_en, cnt_clr, cnt_inc, rem_dec, err_set;
    logic             start_eff;

    // Floor is the larger of MIN_PERIOD and FIRE_HOLD+1 so WAIT is never empty.
    function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
        logic [CNT_W-1:0] floor_v;
        floor_v = (MIN_PERIOD > FIRE_HOLD) ? CNT_W'(MIN_PERIOD) : CNT_W'(FIRE_HOLD + 1);
        return (p < floor_v) ? floor_v : p;
    endfunction

    pulse_cfg_regs #(.CNT_W(CNT_W)) u_cfg_regs (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .cfg_we     (cfg.cfg_we),
        .cfg_addr   (cfg.cfg_addr),
        .cfg_wdata  (cfg.cfg_wdata),
        .key_trig   (key_trig),
        .stg_width1 (stg_width1),
        .stg_width2 (stg_width2),
        .stg_gap    (stg_gap),
        .stg_count  (stg_count),
        .stg_period (stg_period),
        .start_req  (start_req),
        .abort_req  (abort_req),
        .clr_err    (clr_err)
    );

    // Abort takes precedence over a start carried in the same write.
    assign start_eff = start_req && !abort_req;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_n;
    end

    always_comb begin
        state_n = state;
        load_en = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        rem_dec = 1'b0;
        err_set = 1'b0;
        case (state)
            IDLE: begin
                if (start_eff) begin
                    if (stg_width1 != 16'd0) state_n = LOAD;
                    else                     err_set = 1'b1;
                end
            end
            LOAD: begin
                load_en = 1'b1;
                cnt_clr = 1'b1;
                state_n = abort_req ? DONE : FIRE;
            end
            FIRE: begin
                if (abort_req) begin
                    state_n = DONE;
                end else begin
                    cnt_inc = 1'b1;
                    if (cnt == CNT_W'(FIRE_HOLD - 1)) state_n = WAIT;
                end
            end
            WAIT: begin
                if (abort_req) begin
                    state_n = DONE;
                end else if (cnt == period_act - CNT_W'(1)) begin
                    if (remaining == 16'd1) begin
                        state_n = DONE;
                    end else begin
                        rem_dec = (remaining != 16'd0);
                        cnt_clr = 1'b1;
                        state_n = FIRE;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Active copies move only on LOAD; host writes land in the staged set.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pulse_width1 <= '0;
            pulse_width2 <= '0;
            pulse_gap    <= '0;
            period_act   <= '0;
            remaining    <= '0;
        end else if (load_en) begin
            pulse_width1 <= stg_width1;
            pulse_width2 <= stg_width2;
            pulse_gap    <= stg_gap;
            period_act   <= clamp_period(stg_period);
            remaining    <= stg_count;
        end else if (rem_dec) begin
            remaining    <= remaining - 16'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)   cfg_err <= 1'b0;
        else if (err_set) cfg_err <= 1'b1;
        else if (clr_err) cfg_err <= 1'b0;
    end

    assign fire = (state == FIRE);
    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_pulse_burst_ctrl.sv
// Directed bench for pulse_burst_ctrl: hand-computed trigger timing, shadowing, abort, refusal and reset.
module tb_pulse_burst_ctrl;
    import pulse_ctrl_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        key_trig = 1'b0;
    logic [15:0] pulse_width1, pulse_width2, pulse_gap;
    logic        fire, busy, done, cfg_err;

    pulse_burst_ctrl_if cfg_bus ();

    pulse_burst_ctrl #(.FIRE_HOLD(4), .MIN_PERIOD(16), .CNT_W(32)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .cfg          (cfg_bus),
        .key_trig     (key_trig),
        .pulse_width1 (pulse_width1),
        .pulse_width2 (pulse_width2),
        .pulse_gap    (pulse_gap),
        .fire         (fire),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err)
    );

    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int   rise_q[$];
    int   hi_q[$];
    int   done_q[$];
    logic fire_d = 1'b0;
    int   hi_cnt = 0;

    always @(negedge sys_clk) begin
        if (fire && !fire_d) rise_q.push_back(cyc);
        if (fire) hi_cnt <= hi_cnt + 1;
        else if (fire_d) begin
            hi_q.push_back(hi_cnt);
            hi_cnt <= 0;
        end
        if (done) done_q.push_back(cyc);
        fire_d <= fire;
    end

    int passes = 0;
    int total  = 0;
    int t_wr, t0, t1, nd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge sys_clk);
        cfg_bus.cfg_we    = 1'b1;
        cfg_bus.cfg_addr  = a;
        cfg_bus.cfg_wdata = d;
        t_wr = cyc;
        @(negedge sys_clk);
        cfg_bus.cfg_we    = 1'b0;
    endtask

    task automatic key_pulse();
        @(negedge sys_clk);
        key_trig = 1'b1;
        t_wr = cyc;
        @(negedge sys_clk);
        key_trig = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge sys_clk);
    endtask

    task automatic clear_mon();
        rise_q.delete();
        hi_q.delete();
        done_q.delete();
    endtask

    initial begin
        cfg_bus.cfg_we    = 1'b0;
        cfg_bus.cfg_addr  = '0;
        cfg_bus.cfg_wdata = '0;
        repeat (3) @(negedge sys_clk);
        chk("rst_fire", fire, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_w1", pulse_width1, 0);
        chk("rst_gap", pulse_gap, 0);
        sys_rst_n = 1'b1;

        // Shape and count
        wr(ADDR_W1, 10); wr(ADDR_W2, 5); wr(ADDR_GAP, 3);
        wr(ADDR_COUNT, 3); wr(ADDR_PER, 100);
        clear_mon();
        wr(ADDR_CTRL, 1); t0 = t_wr;
        chk("load_busy", busy, 1);
        chk("load_fire", fire, 0);
        chk("load_w1_old", pulse_width1, 0);
        @(negedge sys_clk);
        chk("act_w1", pulse_width1, 10);
        chk("act_w2", pulse_width2, 5);
        chk("act_gap", pulse_gap, 3);
        chk("fire_rise", fire, 1);
        wait_until(t0 + 302);
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 1);
        @(negedge sys_clk);
        chk("busy_after", busy, 0);
        chk("done_after", done, 0);
        wait_until(t0 + 310);
        chk("n_rises", rise_q.size(), 3);
        if (rise_q.size() == 3) begin
            chk("rise0", rise_q[0], t0 + 2);
            chk("rise1", rise_q[1], t0 + 102);
            chk("rise2", rise_q[2], t0 + 202);
        end
        chk("n_highs", hi_q.size(), 3);
        foreach (hi_q[i]) chk("high_len", hi_q[i], 4);
        chk("n_done", done_q.size(), 1);
        if (done_q.size() == 1) chk("done_cyc", done_q[0], t0 + 302);

        // Period clamp
        wr(ADDR_PER, 5); wr(ADDR_COUNT, 2);
        clear_mon();
        wr(ADDR_CTRL, 1); t0 = t_wr;
        wait_until(t0 + 40);
        chk("clamp_rises", rise_q.size(), 2);
        if (rise_q.size() == 2) chk("clamp_space", rise_q[1] - rise_q[0], 16);
        if (done_q.size() >= 1) chk("clamp_done", done_q[0], t0 + 34);
        else chk("clamp_done", 0, t0 + 34);

        // Refused start, clear, set-wins, abort beats start
        wr(ADDR_W1, 0);
        wr(ADDR_CTRL, 1);
        chk("refuse_err", cfg_err, 1);
        chk("refuse_busy", busy, 0);
        wr(ADDR_CTRL, 8);
        chk("err_clear", cfg_err, 0);
        wr(ADDR_CTRL, 9);
        chk("err_set_wins", cfg_err, 1);
        wr(ADDR_CTRL, 8);
        wr(ADDR_W1, 1);
        wr(ADDR_CTRL, 1); t0 = t_wr;
        chk("retry_busy", busy, 1);
        chk("retry_err", cfg_err, 0);
        wait_until(t0 + 40);
        wr(ADDR_CTRL, 3);
        chk("abort_start_busy", busy, 0);
        chk("abort_start_err", cfg_err, 0);

        // Abort in continuous mode at counter 20 of the fifth WAIT
        wr(ADDR_COUNT, 0); wr(ADDR_PER, 50);
        clear_mon();
        wr(ADDR_CTRL, 1); t0 = t_wr;
        wait_until(t0 + 221);
        chk("pre_abort_busy", busy, 1);
        wr(ADDR_CTRL, 2);
        chk("abort_done", done, 1);
        chk("abort_fire", fire, 0);
        @(negedge sys_clk);
        chk("abort_idle", busy, 0);
        chk("abort_rises", rise_q.size(), 5);
        chk("abort_n_done", done_q.size(), 1);

        // Key start and shadowing
        wr(ADDR_CTRL, 0);
        key_pulse();
        chk("key_dis", busy, 0);
        wr(ADDR_COUNT, 1); wr(ADDR_PER, 20); wr(ADDR_W1, 7);
        wr(ADDR_CTRL, 4);
        key_pulse(); t0 = t_wr;
        chk("key_busy", busy, 1);
        wait_until(t0 + 5);
        wr(ADDR_W1, 99);
        chk("shadow_mid", pulse_width1, 7);
        wait_until(t0 + 25);
        chk("key_end_busy", busy, 0);
        chk("shadow_after", pulse_width1, 7);
        key_pulse(); t1 = t_wr;
        wait_until(t1 + 2);
        chk("shadow_reload", pulse_width1, 99);
        wait_until(t1 + 25);

        // Same-cycle write and key press use pre-write staged values and key_en
        wr(ADDR_W1, 0);
        @(negedge sys_clk);
        cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = ADDR_W1; cfg_bus.cfg_wdata = 5;
        key_trig = 1'b1;
        @(negedge sys_clk);
        cfg_bus.cfg_we = 1'b0; key_trig = 1'b0;
        chk("pre_w1_refuse", cfg_err, 1);
        chk("pre_w1_busy", busy, 0);
        wr(ADDR_CTRL, 12);
        chk("err_clr_keep", cfg_err, 0);
        @(negedge sys_clk);
        cfg_bus.cfg_we = 1'b1; cfg_bus.cfg_addr = ADDR_CTRL; cfg_bus.cfg_wdata = 0;
        key_trig = 1'b1;
        t0 = cyc;
        @(negedge sys_clk);
        cfg_bus.cfg_we = 1'b0; key_trig = 1'b0;
        chk("pre_keyen_start", busy, 1);
        wait_until(t0 + 25);
        chk("pre_keyen_end", busy, 0);

        // Reset mid-burst
        wr(ADDR_COUNT, 3); wr(ADDR_PER, 100);
        wr(ADDR_CTRL, 1); t0 = t_wr;
        wait_until(t0 + 3);
        chk("rst_mid_fire_on", fire, 1);
        nd = done_q.size();
        #3 sys_rst_n = 1'b0;
        #1;
        chk("rst_mid_fire", fire, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_w1", pulse_width1, 0);
        chk("rst_mid_w2", pulse_width2, 0);
        chk("rst_mid_gap", pulse_gap, 0);
        chk("rst_mid_done", done, 0);
        repeat (5) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        wait_until(t0 + 320);
        chk("rst_no_done", done_q.size(), nd);
        chk("rst_idle", busy, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/pulse_burst_ctrl.md
# pulse_burst_ctrl

Sequencer and configuration owner for the dual-channel pulse generator. It takes register writes from the UART command decoder and single-cycle start requests from the UART path or a debounced key. It then drives the generator's trigger and pulse-shape inputs to produce a burst of N pulse pairs spaced by a programmable period. The shape registers are double-buffered, so host writes never disturb a burst in flight.

## Interface
Parameters:
- FIRE_HOLD, 4: sys_clk cycles that `fire` is held high per trigger.
- MIN_PERIOD, 16: smallest legal trigger period in sys_clk cycles; smaller programmed values are clamped up to it.
- CNT_W, 32: width of the period counter and the period register.

Ports (clock and reset first):
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  reset, asynchronous, active-low; clock sys_clk.
- cfg_we  in  1  register write strobe, one cycle.
- cfg_addr  in  3  register address.
- cfg_wdata  in  32  write data.
- key_trig  in  1  debounced key press, one-cycle pulse.
- pulse_width1  out  16  generator first-pulse width (active copy).
- pulse_width2  out  16  generator second-pulse width (active copy).
- pulse_gap  out  16  generator inter-pulse gap (active copy).
- fire  out  1  trigger level to the generator.
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse when a burst completes or is aborted.
- cfg_err  out  1  sticky; set when a start is refused.

## Operation
Register map. Write-only; unused bits are ignored; an unmapped address is a no-op.
- 0: staged width1[15:0].
- 1: staged width2[15:0].
- 2: staged gap[15:0].
- 3: staged burst count[15:0]. A value of 0 means continuous operation until abort.
- 4: staged period[CNT_W-1:0].
- 5: control. Bit0 = start (self-clearing). Bit1 = abort (self-clearing). Bit2 = key_en (stored). Bit3 = clear cfg_err.

Start request:
- A start request is a control write with bit0 = 1, or `key_trig` while key_en = 1.
- In IDLE it is accepted only if staged width1 ≠ 0.
- Otherwise it is refused: cfg_err is set and the state does not change.
- In any state other than IDLE, start requests are ignored silently.

States:
- IDLE: fire = 0, busy = 0. An accepted start goes to LOAD.
- LOAD (1 cycle):
  - Copy staged width1/width2/gap to the active outputs.
  - remaining ← burst count.
  - period_act ← max(period, MIN_PERIOD, FIRE_HOLD+1).
  - Clear the period counter. Go to FIRE.
- FIRE: fire = 1 for FIRE_HOLD cycles; the counter runs. Go to WAIT.
- WAIT: fire = 0. When counter = period_act−1:
  - If remaining = 1, go to DONE.
  - Otherwise decrement remaining (not when in continuous mode), clear the counter, and go to FIRE.
- DONE (1 cycle): done = 1. Go to IDLE.

Abort:
- An abort in LOAD/FIRE/WAIT forces fire = 0 and goes to DONE the next cycle.
- Abort in IDLE or DONE is a no-op.

Staging and active registers:
- Staged-register writes are accepted in every state.
- Active registers change only in LOAD.

## Timing
Reset values:
- All active and staged registers = 0; key_en = 0.
- fire = busy = done = cfg_err = 0; state = IDLE.

Start latency:
- Start write at cycle t: LOAD at t+1, fire rises at t+2.
- busy rises at t+1 and falls the cycle after DONE.

Trigger spacing:
- Rising edges of fire are exactly period_act cycles apart.
- Each fire high time is exactly FIRE_HOLD cycles.
- Last trigger rises at cycle r: done pulses at r+period_act, busy is low from r+period_act+1.

Simultaneous events:
- Abort and start in the same write (bits 0 and 1 both set): abort wins; in IDLE nothing starts.
- Same-cycle cfg_we plus key_trig: the register write is applied. The key start is evaluated against the pre-write staged values and the pre-write key_en.
- Abort during FIRE truncates fire on the next edge.
- Same cycle as a clear-cfg_err write, a refused start sets cfg_err (set wins).

Reset mid-burst: asynchronously returns to IDLE with all outputs at their reset values. No done pulse is produced.

Arithmetic:
- Counter width is CNT_W; it is cleared before it can wrap.
- The remaining count is 16 bits; continuous mode never decrements it.

## Structure
- Package pulse_ctrl_pkg holds:
  - address constants ADDR_W1..ADDR_CTRL;
  - control bit indices;
  - state enum (IDLE, LOAD, FIRE, WAIT, DONE);
  - default MIN_PERIOD.
- Sub-module pulse_cfg_regs holds the staged registers, key_en, and the write decode. It exports strobes start_req, abort_req and clr_err.
- The top level holds the FSM, counters and active registers.

## Test plan
- Shape and count:
  - Stimulus: write w1=10, w2=5, gap=3, count=3, period=100, then start.
  - Required: three fire pulses of 4 cycles; rising edges at t+2, t+102, t+202; done at t+302.
  - Required: outputs read 10/5/3 from t+2 onward.
- Clamp:
  - Stimulus: period=5, count=2.
  - Required: fire edges 16 cycles apart.
- Refused start:
  - Stimulus: w1=0, then start.
  - Required: cfg_err=1, busy stays 0.
  - Stimulus: clear cfg_err, set w1=1, start.
  - Required: burst runs.
- Abort and continuous mode:
  - Stimulus: count=0, period=50; abort at the 5th WAIT cycle 20.
  - Required: done the next cycle; exactly 5 fire pulses.
- Key start and shadowing:
  - Stimulus: key_en=0, key_trig.
  - Required: ignored.
  - Stimulus: key_en=1, key_trig; during the burst, write w1=99.
  - Required: pulse_width1 stays at the old value until the next LOAD.
- Reset mid-burst:
  - Stimulus: assert sys_rst_n low during FIRE.
  - Required: fire, busy and all outputs drop to 0 immediately; no done pulse.
